// File: rtl/video_timing_pkg.sv
// Shared types and helpers for the video timing generator.
// Mode encoding and per-mode line counts live here.
package video_timing_pkg;

    typedef struct packed {
        logic scandouble;
        logic pal;
    } mode_t;

    function automatic int v_total(mode_t m, int total_n, int total_p);
        return m.pal ? total_p : total_n;
    endfunction

    function automatic int v_active(mode_t m, int active_n, int active_p);
        return m.pal ? active_p : active_n;
    endfunction

    // Terminal divider count (D-1) for a given mode.
    function automatic int ce_last(mode_t m, int ce_div);
        return (m.scandouble ? ce_div / 2 : ce_div) - 1;
    endfunction

    function automatic bit ce_div_ok(int ce_div);
        return (ce_div >= 2) && ((ce_div % 2) == 0);
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Mode inputs and raster/sync outputs of the video timing generator.
// The generator takes the master side, video consumers the slave side.
interface video_timing_gen_if #(
    parameter int HW = 10,
    parameter int VW = 10
);
    import video_timing_pkg::*;

    logic          pal;
    logic          scandouble;
    logic          ce_pix;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          line_rep;
    logic          HBlank;
    logic          VBlank;
    logic          HSync;
    logic          VSync;
    logic          frame_start;
    mode_t         mode;

    modport master (
        input  pal,
        input  scandouble,
        output ce_pix,
        output hcount,
        output vcount,
        output line_rep,
        output HBlank,
        output VBlank,
        output HSync,
        output VSync,
        output frame_start,
        output mode
    );

    modport slave (
        output pal,
        output scandouble,
        input  ce_pix,
        input  hcount,
        input  vcount,
        input  line_rep,
        input  HBlank,
        input  VBlank,
        input  HSync,
        input  VSync,
        input  frame_start,
        input  mode
    );

endinterface

// File: rtl/video_ce_div.sv
// Pixel clock-enable divider: counts 0..last and flags the terminal count.
// The flag is registered so it sits in the same cycle as cnt_q == last.
module video_ce_div #(
    parameter int CW = 2
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          restart,
    input  logic [CW-1:0] last,
    input  logic [CW-1:0] last_nxt,
    output logic          ce_nxt,
    output logic          ce_pix
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          ce_pix_q;
    logic          ce_pix_d;

    // last_nxt is the terminal count of the mode in force after this edge,
    // so the enable lines up with the new rate straight after a reload.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (reset || restart || (cnt_q >= last)) begin
            cnt_d = '0;
        end
        ce_pix_d = !reset && (cnt_d == last_nxt);
    end

    always_ff @(posedge clk_sys) begin
        cnt_q    <= cnt_d;
        ce_pix_q <= ce_pix_d;
    end

    assign ce_nxt = ce_pix_d;
    assign ce_pix = ce_pix_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster counters, blank/sync decode and frame-boundary mode latch.
// Flags are decoded from next-state counters so they track the counters.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int HW         = 10,
    parameter int VW         = 10,
    parameter int CE_DIV     = 4,
    parameter int H_ACTIVE   = 320,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 32,
    parameter int H_TOTAL    = 400,
    parameter int V_ACTIVE_N = 240,
    parameter int V_TOTAL_N  = 262,
    parameter int V_ACTIVE_P = 288,
    parameter int V_TOTAL_P  = 312,
    parameter int V_FP       = 3,
    parameter int V_SYNC     = 3
) (
    input logic               clk_sys,
    input logic               reset,
    video_timing_gen_if.master vid
);

    localparam int CW = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_ON  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_OFF = HW'(H_ACTIVE + H_FP + H_SYNC);

    if (!ce_div_ok(CE_DIV)) begin : g_bad_ce_div
        $error("CE_DIV must be even and at least 2");
    end
    if (H_ACTIVE + H_FP + H_SYNC > H_TOTAL) begin : g_bad_h
        $error("horizontal active+porch+sync exceeds H_TOTAL");
    end
    if (V_ACTIVE_N + V_FP + V_SYNC > V_TOTAL_N) begin : g_bad_vn
        $error("NTSC active+porch+sync exceeds V_TOTAL_N");
    end
    if (V_ACTIVE_P + V_FP + V_SYNC > V_TOTAL_P) begin : g_bad_vp
        $error("PAL active+porch+sync exceeds V_TOTAL_P");
    end
    if (H_TOTAL >= (1 << HW)) begin : g_bad_hw
        $error("H_TOTAL does not fit in HW bits");
    end
    if (V_TOTAL_P >= (1 << VW)) begin : g_bad_vw
        $error("V_TOTAL_P does not fit in VW bits");
    end

    mode_t         mode_q, mode_d, mode_in;
    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    logic          line_rep_q, line_rep_d;
    logic          hblank_q, hblank_d;
    logic          hsync_q, hsync_d;
    logic          vblank_q, vblank_d;
    logic          vsync_q, vsync_d;
    logic          frame_start_q, frame_start_d;

    logic [VW-1:0] v_last_q, v_last_d;
    logic [VW-1:0] v_act_d;
    logic [CW-1:0] ce_last_q, ce_last_d;
    logic          h_wrap;
    logic          v_inc;
    logic          frame_wrap;
    logic          ce_pix;
    logic          ce_nxt;

    always_comb begin
        mode_in.scandouble = vid.scandouble;
        mode_in.pal        = vid.pal;

        v_last_q  = VW'(v_total(mode_q, V_TOTAL_N, V_TOTAL_P) - 1);
        ce_last_q = CW'(ce_last(mode_q, CE_DIV));

        // In scandouble a source line ends only after its repeat copy.
        h_wrap     = (hcount_q == H_LAST);
        v_inc      = h_wrap && (!mode_q.scandouble || line_rep_q);
        frame_wrap = ce_pix && v_inc && (vcount_q == v_last_q);

        mode_d     = mode_q;
        hcount_d   = hcount_q;
        vcount_d   = vcount_q;
        line_rep_d = line_rep_q;

        if (reset) begin
            mode_d     = mode_in;
            hcount_d   = '0;
            vcount_d   = '0;
            line_rep_d = 1'b0;
        end else if (ce_pix) begin
            if (frame_wrap) begin
                mode_d = mode_in;
            end
            hcount_d = h_wrap ? '0 : hcount_q + HW'(1);
            if (h_wrap) begin
                line_rep_d = mode_q.scandouble && !line_rep_q;
            end
            if (v_inc) begin
                vcount_d = (vcount_q == v_last_q) ? '0 : vcount_q + VW'(1);
            end
        end

        v_last_d  = VW'(v_total(mode_d, V_TOTAL_N, V_TOTAL_P) - 1);
        v_act_d   = VW'(v_active(mode_d, V_ACTIVE_N, V_ACTIVE_P));
        ce_last_d = CW'(ce_last(mode_d, CE_DIV));
    end

    video_ce_div #(
        .CW(CW)
    ) u_ce_div (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .restart  (frame_wrap),
        .last     (ce_last_q),
        .last_nxt (ce_last_d),
        .ce_nxt   (ce_nxt),
        .ce_pix   (ce_pix)
    );

    always_comb begin
        hblank_d = (hcount_d >= H_ACT);
        hsync_d  = (hcount_d >= HS_ON) && (hcount_d < HS_OFF);
        vblank_d = (vcount_d >= v_act_d);
        vsync_d  = (vcount_d >= v_act_d + VW'(V_FP)) &&
                   (vcount_d <  v_act_d + VW'(V_FP + V_SYNC));
        // Marks the enable that wraps the raster back to (0,0).
        frame_start_d = ce_nxt &&
                        (hcount_d == H_LAST) &&
                        (vcount_d == v_last_d) &&
                        (line_rep_d || !mode_d.scandouble);
    end

    always_ff @(posedge clk_sys) begin
        mode_q        <= mode_d;
        hcount_q      <= hcount_d;
        vcount_q      <= vcount_d;
        line_rep_q    <= line_rep_d;
        hblank_q      <= hblank_d;
        hsync_q       <= hsync_d;
        vblank_q      <= vblank_d;
        vsync_q       <= vsync_d;
        frame_start_q <= frame_start_d;
    end

    assign vid.ce_pix      = ce_pix;
    assign vid.hcount      = hcount_q;
    assign vid.vcount      = vcount_q;
    assign vid.line_rep    = line_rep_q;
    assign vid.HBlank      = hblank_q;
    assign vid.VBlank      = vblank_q;
    assign vid.HSync       = hsync_q;
    assign vid.VSync       = vsync_q;
    assign vid.frame_start = frame_start_q;
    assign vid.mode        = mode_q;

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised video timing generator for the test cores. It produces the pixel clock enable, raster counters, blanking and sync for the emu video path, and drives CE_PIXEL, VGA_HS/VS and VGA_DE. It adds runtime NTSC/PAL selection and a scandoubled mode. Both are latched only at frame boundaries so a mode change never produces a torn frame.

## Interface
Parameters:
- HW, 10: horizontal counter width.
- VW, 10: vertical counter width.
- CE_DIV, 4: clk_sys cycles per pixel in normal mode. Must be even and ≥2.
- H_ACTIVE, 320; H_FP, 16; H_SYNC, 32; H_TOTAL, 400: horizontal timing, in pixels.
- V_ACTIVE_N, 240; V_TOTAL_N, 262: NTSC lines.
- V_ACTIVE_P, 288; V_TOTAL_P, 312: PAL lines.
- V_FP, 3; V_SYNC, 3: vertical front porch and sync length, in lines, for both modes.

Ports:
- clk_sys in 1: system clock.
- reset in 1: synchronous, active-high.
- pal in 1: 0 = NTSC, 1 = PAL. Sampled at frame boundary.
- scandouble in 1: 1 = double pixel rate, each line emitted twice. Sampled at frame boundary.
- ce_pix out 1: one-cycle pixel enable.
- hcount out HW: current pixel column.
- vcount out VW: current source line.
- line_rep out 1: 1 on the repeated (second) copy of a line. 0 when not scandoubled.
- HBlank, VBlank, HSync, VSync out 1 each: active-high.
- frame_start out 1: high with ce_pix at raster (0,0).
- mode out 2: latched {scandouble, pal}.

## Operation
- The divider counts 0..D-1 with D = CE_DIV, or CE_DIV/2 when the latched scandouble bit is set. ce_pix is high in the cycle the divider equals D-1.
- Raster counters advance only on ce_pix.
- hcount wraps H_TOTAL-1 → 0. On each wrap:
  - If scandouble: line_rep toggles, and vcount increments only when line_rep goes 1 → 0.
  - Otherwise: vcount increments and line_rep stays 0.
- vcount wraps V_TOTAL-1 → 0. V_TOTAL comes from the latched pal bit.
- At the wrap to (0,0), with line_rep going to 0:
  - pal and scandouble are re-latched into mode.
  - the divider restarts with the new D.
  - frame_start pulses.
- Decode, evaluated on the registered counters:
  - HBlank = hcount ≥ H_ACTIVE.
  - HSync = H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC.
  - VBlank = vcount ≥ V_ACTIVE.
  - VSync = V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC.
- All outputs are registered. Decoded flags change in the same cycle as the counters they describe.
- Changes to pal or scandouble mid-frame have no effect until the next (0,0) wrap. Toggling them back and forth within a frame is invisible.

## Timing
- Reset values:
  - divider 0, hcount 0, vcount 0, line_rep 0.
  - ce_pix 0, frame_start 0.
  - HBlank, VBlank, HSync and VSync all 0, since (0,0) is an active pixel.
  - mode = {scandouble, pal} as sampled during reset.
- First ce_pix after reset deassert: D cycles later. The counter advance to (1,0) occurs on that ce_pix.
- Frame period in clk_sys cycles:
  - normal: CE_DIV·H_TOTAL·V_TOTAL.
  - scandoubled: (CE_DIV/2)·H_TOTAL·2·V_TOTAL.
- Defaults: NTSC normal = 419200 cycles; PAL normal = 499200 cycles.
- frame_start is exactly 1 clk_sys cycle wide, coincident with ce_pix.
- Reset asserted mid-frame forces all reset values on the next edge. No partial line is completed.
- Elaboration asserts must check:
  - H_ACTIVE+H_FP+H_SYNC ≤ H_TOTAL.
  - V_ACTIVE+V_FP+V_SYNC ≤ V_TOTAL for both modes.
  - H_TOTAL < 2^HW and V_TOTAL_P < 2^VW.

## Structure
- Package video_timing_pkg holds:
  - the mode_t struct {scandouble, pal}.
  - a v_total(mode) function and a v_active(mode) function.
  - the CE_DIV legality check.
- Sub-module video_ce_div owns the divider, the reload on mode change, and ce_pix generation.
- Counters, decode and mode latch live in video_timing_gen.

## Test plan
- Reset: hold reset 5 cycles, pal=0. Required: all outputs 0 and mode=00. First ce_pix arrives 4 cycles after release.
- NTSC frame: run 2 frames with defaults. Required:
  - frame_start pulses are 419200 cycles apart.
  - HSync is high for hcount 336..367.
  - VSync is high for vcount 243..245.
  - VBlank rises at vcount 240.
- PAL switch mid-frame: set pal=1 at vcount 100. Required: the current frame still wraps at vcount 261. The next frame wraps at 311. mode becomes 01 at frame_start.
- Scandouble: set scandouble=1 before a frame boundary. Required:
  - ce_pix every 2 cycles after frame_start.
  - line_rep alternates each line.
  - vcount increments every second hcount wrap.
  - frame period is 419200 cycles.
- Reset mid-line: assert reset at hcount 200, vcount 50, with the divider mid-count. Required: next cycle hcount=0, vcount=0, ce_pix=0, and HBlank and VBlank both 0.
- Glitch immunity: toggle pal 0→1→0 within one frame. Required: mode never changes and the frame period stays 419200 cycles.
